// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RISC-V control unit.
// Holds the controller state encoding, the opcodes it decodes, and the
// mux/ALU/immediate select encodings shared with the datapath and ALU
// decoder. Also provides the per-state Moore output table.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JALR,
        S_JAL,
        S_LUI,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // pc_update here is only the unconditional write from JAL; the fetch
    // PC increment is gated by mem_ready in the top module.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control-unit bundle between the multicycle controller and the datapath.
// master: controller side (drives enables/selects, sees op and mem_ready).
// slave:  datapath/memory side.
interface main_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic       illegal_instr;
    logic       bus_error;

    modport master (
        input  op, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal_instr, bus_error
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal_instr, bus_error
    );
endinterface

// File: rtl/main_fsm_immsrc_dec.sv
// Immediate-format decoder: opcode to ImmSrc, purely combinational.
// Ports:
//   i_op       opcode from the instruction register
//   o_imm_src  immediate format select for the extender
module immsrc_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);

    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_LW, OP_ITYPE, OP_JALR: o_imm_src = IMM_I;
            OP_SW:                    o_imm_src = IMM_S;
            OP_BRANCH:                o_imm_src = IMM_B;
            OP_JAL:                   o_imm_src = IMM_J;
            OP_AUIPC, OP_LUI:         o_imm_src = IMM_U;
            default:                  o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with a memory ready/request handshake,
// an optional memory-wait watchdog and a selectable illegal-opcode policy.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    controller side of main_fsm_if (op/mem_ready in, enables,
//          selects, ImmSrc and the sticky illegal_instr/bus_error out)
//
// state      | meaning
// -----------+--------------------------------------------------
// FETCH      | read instruction at PC, PC+4 on mem_ready
// DECODE     | read registers, target OldPC+imm into ALUOut
// MEMADR     | rs1+imm address for lw/sw
// MEMREAD    | load access, wait for mem_ready
// MEMWRITE   | store access, MemWrite held until mem_ready
// MEMWB      | write load data to rd
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | write ALUOut to rd
// BEQ        | compare, conditional PC write to ALUOut
// JALR       | rs1+imm target into ALUOut
// JAL        | PC <- ALUOut, OldPC+4 into ALUOut
// LUI        | 0+imm into ALUOut
// ERROR      | halted, all enables off until reset
module main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TRAP_ILLEGAL = 1,
    parameter int MEM_TIMEOUT  = 0,
    parameter int CNT_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.master bus
);

    localparam logic [31:0]      TIMEOUT_U = 32'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic             r_fetch;
    logic             r_illegal;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_wait_cnt;

    state_t           w_next_state;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_illegal_op;
    logic [2:0]       w_imm_src;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);

    // Fires on the cycle the wait count would reach MEM_TIMEOUT; a
    // mem_ready in that same cycle completes the access instead.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_mem_state && !bus.mem_ready &&
                       ((32'(r_wait_cnt) + 32'd1) >= TIMEOUT_U);

    always_comb begin
        w_next_state = r_state;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_ITYPE:     w_next_state = S_EXECUTEI;
                    OP_BRANCH:    w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_JALR:      w_next_state = S_JALR;
                    OP_AUIPC:     w_next_state = S_ALUWB;
                    OP_LUI:       w_next_state = S_LUI;
                    OP_NOP:       w_next_state = S_FETCH;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next_state = (TRAP_ILLEGAL != 0) ? S_ERROR : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:   w_next_state = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) w_next_state = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) w_next_state = S_FETCH;
            S_MEMWB, S_ALUWB, S_BEQ:         w_next_state = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI:   w_next_state = S_ALUWB;
            S_JALR:     w_next_state = S_JAL;
            S_JAL:      w_next_state = S_ALUWB;
            S_ERROR:    w_next_state = S_ERROR;
            default:    w_next_state = S_FETCH;
        endcase
        if (w_timeout) w_next_state = S_ERROR;
    end

    // Outputs are registered from the next state so they line up with
    // r_state without any decode after the flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_ctrl      <= state_ctrl(S_FETCH);
            r_fetch     <= 1'b1;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= state_ctrl(w_next_state);
            r_fetch <= (w_next_state == S_FETCH);
            if (w_illegal_op && (TRAP_ILLEGAL != 0)) r_illegal <= 1'b1;
            if (w_timeout) r_bus_error <= 1'b1;
            if ((w_next_state != r_state) || bus.mem_ready) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state && (r_wait_cnt != CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    immsrc_dec u_immsrc_dec (
        .i_op      (bus.op),
        .o_imm_src (w_imm_src)
    );

    assign bus.mem_req       = r_ctrl.mem_req;
    assign bus.AdrSrc        = r_ctrl.adr_src;
    assign bus.IRWrite       = r_fetch & bus.mem_ready;
    assign bus.PCUpdate      = r_ctrl.pc_update | (r_fetch & bus.mem_ready);
    assign bus.Branch        = r_ctrl.branch;
    assign bus.RegWrite      = r_ctrl.reg_write;
    assign bus.MemWrite      = r_ctrl.mem_write;
    assign bus.ALUSrcA       = r_ctrl.alu_src_a;
    assign bus.ALUSrcB       = r_ctrl.alu_src_b;
    assign bus.ALUOp         = r_ctrl.alu_op;
    assign bus.ResultSrc     = r_ctrl.result_src;
    assign bus.ImmSrc        = w_imm_src;
    assign bus.illegal_instr = r_illegal;
    assign bus.bus_error     = r_bus_error;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: two instances (trap + 4-cycle watchdog, and
// retire-as-NOP without watchdog) driven by directed queues followed by
// random opcodes, mem_ready and resets. Each instance is compared every
// cycle against an instruction-level model that expands an opcode into its
// list of phases, plus a retire-to-retire cycle count check.
module tb_main_fsm;

    localparam int N_CYC = 4000;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWB = 5,
                   P_XR = 6, P_XI = 7, P_AWB = 8, P_BEQ = 9, P_JALR = 10,
                   P_JAL = 11, P_LUI = 12, P_ERR = 13;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    main_fsm_if bus0 ();
    main_fsm_if bus1 ();

    main_fsm #(.TRAP_ILLEGAL(1), .MEM_TIMEOUT(4)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    main_fsm #(.TRAP_ILLEGAL(0), .MEM_TIMEOUT(0)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    wire [14:0] obs_out0 = {bus0.mem_req, bus0.AdrSrc, bus0.IRWrite, bus0.PCUpdate,
                            bus0.Branch, bus0.RegWrite, bus0.MemWrite, bus0.ALUSrcA,
                            bus0.ALUSrcB, bus0.ALUOp, bus0.ResultSrc};
    wire [14:0] obs_out1 = {bus1.mem_req, bus1.AdrSrc, bus1.IRWrite, bus1.PCUpdate,
                            bus1.Branch, bus1.RegWrite, bus1.MemWrite, bus1.ALUSrcA,
                            bus1.ALUSrcB, bus1.ALUOp, bus1.ResultSrc};

    bit c_trap [2] = '{1'b1, 1'b0};
    int c_to   [2] = '{4, 0};

    int   m_ph   [2];
    int   m_pos  [2];
    int   m_len  [2];
    int   m_wait [2];
    int   m_errc [2];
    int   m_seq  [2][4];
    bit   m_ill  [2];
    bit   m_bus  [2];

    logic [6:0] cur_op  [2];
    bit         cc_valid[2];
    int         cc_cnt  [2];
    int         cc_waits[2];
    logic [6:0] cc_op   [2];
    logic       s_rst   [2];
    logic       s_rdy   [2];

    logic [6:0] q_op0 [$];
    logic [6:0] q_op1 [$];
    logic       q_rdy0[$];
    logic       q_rdy1[$];

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
                                  7'b0110111};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_mem(input int ph);
        return (ph == P_F) || (ph == P_MR) || (ph == P_MW);
    endfunction

    // {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
    //  ALUSrcA, ALUSrcB, ALUOp, ResultSrc}
    function automatic logic [14:0] exp_out(input int ph, input logic rdy);
        logic mr = 0, adr = 0, irw = 0, pcu = 0, br = 0, rw = 0, mw = 0;
        logic [1:0] a = 0, b = 0, alu = 0, res = 0;
        case (ph)
            P_F:    begin mr = 1; irw = rdy; pcu = rdy; b = 2'b10; res = 2'b10; end
            P_D:    begin a = 2'b01; b = 2'b01; end
            P_MA:   begin a = 2'b10; b = 2'b01; end
            P_MR:   begin mr = 1; adr = 1; end
            P_MW:   begin mr = 1; adr = 1; mw = 1; end
            P_MWB:  begin res = 2'b01; rw = 1; end
            P_XR:   begin a = 2'b10; alu = 2'b10; end
            P_XI:   begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            P_AWB:  begin rw = 1; end
            P_BEQ:  begin a = 2'b10; alu = 2'b01; br = 1; end
            P_JALR: begin a = 2'b10; b = 2'b01; end
            P_JAL:  begin a = 2'b01; b = 2'b10; pcu = 1; end
            P_LUI:  begin a = 2'b11; b = 2'b01; end
            default: ;
        endcase
        return {mr, adr, irw, pcu, br, rw, mw, a, b, alu, res};
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0010111, 7'b0110111: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int base_cycles(input logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011, 7'b0010011: return 4;
            7'b1100011: return 3;
            7'b1101111: return 4;
            7'b1100111: return 5;
            7'b0010111: return 3;
            7'b0110111: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic load_seq(input int i, input logic [6:0] op, output bit legal);
        legal = 1;
        m_len[i] = 0;
        case (op)
            7'b0000011: begin m_seq[i][0] = P_MA;   m_seq[i][1] = P_MR;  m_seq[i][2] = P_MWB; m_len[i] = 3; end
            7'b0100011: begin m_seq[i][0] = P_MA;   m_seq[i][1] = P_MW;  m_len[i] = 2; end
            7'b0110011: begin m_seq[i][0] = P_XR;   m_seq[i][1] = P_AWB; m_len[i] = 2; end
            7'b0010011: begin m_seq[i][0] = P_XI;   m_seq[i][1] = P_AWB; m_len[i] = 2; end
            7'b1100011: begin m_seq[i][0] = P_BEQ;  m_len[i] = 1; end
            7'b1101111: begin m_seq[i][0] = P_JAL;  m_seq[i][1] = P_AWB; m_len[i] = 2; end
            7'b1100111: begin m_seq[i][0] = P_JALR; m_seq[i][1] = P_JAL; m_seq[i][2] = P_AWB; m_len[i] = 3; end
            7'b0010111: begin m_seq[i][0] = P_AWB;  m_len[i] = 1; end
            7'b0110111: begin m_seq[i][0] = P_LUI;  m_seq[i][1] = P_AWB; m_len[i] = 2; end
            7'b0000000: m_len[i] = 0;
            default:    legal = 0;
        endcase
    endtask

    task automatic advance(input int i);
        if (m_ph[i] == P_F) begin
            m_ph[i] = P_D;
        end else if (m_pos[i] < m_len[i]) begin
            m_ph[i] = m_seq[i][m_pos[i]];
            m_pos[i]++;
        end else begin
            m_ph[i] = P_F;
        end
    endtask

    task automatic model_step(input int i, input logic rst, input logic rdy, input logic [6:0] op);
        bit legal;
        if (rst) begin
            m_ph[i] = P_F; m_pos[i] = 0; m_len[i] = 0; m_wait[i] = 0;
            m_ill[i] = 0; m_bus[i] = 0; m_errc[i] = 0;
            return;
        end
        if (m_ph[i] == P_ERR) begin
            // halted
        end else if (is_mem(m_ph[i])) begin
            if (rdy) begin
                m_wait[i] = 0;
                advance(i);
            end else if (c_to[i] > 0 && m_wait[i] + 1 >= c_to[i]) begin
                m_ph[i] = P_ERR; m_bus[i] = 1; m_wait[i] = 0;
            end else begin
                m_wait[i]++;
            end
        end else if (m_ph[i] == P_D) begin
            load_seq(i, op, legal);
            m_pos[i] = 0;
            if (!legal) begin
                m_len[i] = 0;
                if (c_trap[i]) begin m_ph[i] = P_ERR; m_ill[i] = 1; end
                else m_ph[i] = P_F;
            end else begin
                advance(i);
            end
        end else begin
            advance(i);
        end
        if (m_ph[i] == P_ERR) m_errc[i]++;
        else m_errc[i] = 0;
    endtask

    function automatic logic [6:0] rand_op();
        int k = $urandom_range(0, 10);
        if (k < 9) return legal_ops[k];
        if (k == 9) return 7'b0000000;
        return 7'($urandom_range(0, 127));
    endfunction

    initial begin
        logic [14:0] got;
        logic [2:0]  got_imm;
        logic        got_ill, got_bus, fetch_done, rnd;

        // inst 0: lw, sw with 2 store waits, jalr, illegal (trap), fetch timeout,
        // fetch completing on the 4th wait cycle, then lw
        q_op0  = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b1111111, 7'b0000011};
        q_rdy0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        // inst 1: illegal retired as NOP, lui, auipc, long fetch wait then sw
        q_op1  = '{7'b1111111, 7'b0110111, 7'b0010111, 7'b0100011};
        q_rdy1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 2; i++) begin
            cur_op[i] = 7'b0; cc_valid[i] = 0; cc_cnt[i] = 0; cc_waits[i] = 0;
            cc_op[i] = 7'b0; m_ph[i] = P_F; m_errc[i] = 0; m_ill[i] = 0; m_bus[i] = 0;
            m_pos[i] = 0; m_len[i] = 0; m_wait[i] = 0;
        end
        bus0.op = 7'b0; bus0.mem_ready = 1'b0;
        bus1.op = 7'b0; bus1.mem_ready = 1'b0;

        @(negedge clk);
        for (int c = 0; c < N_CYC; c++) begin
            cyc = c;
            for (int i = 0; i < 2; i++) begin
                rnd = (i == 0) ? (q_op0.size() == 0 && q_rdy0.size() == 0)
                               : (q_op1.size() == 0 && q_rdy1.size() == 0);
                s_rst[i] = (c == 0) || (m_errc[i] >= 3) ||
                           (rnd && m_ph[i] == P_MW && $urandom_range(0, 7) == 0) ||
                           (rnd && $urandom_range(0, 199) == 0);
                if (!s_rst[i] && is_mem(m_ph[i]) && i == 0 && q_rdy0.size() != 0)
                    s_rdy[i] = q_rdy0.pop_front();
                else if (!s_rst[i] && is_mem(m_ph[i]) && i == 1 && q_rdy1.size() != 0)
                    s_rdy[i] = q_rdy1.pop_front();
                else
                    s_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            rst0 = s_rst[0]; bus0.mem_ready = s_rdy[0]; bus0.op = cur_op[0];
            rst1 = s_rst[1]; bus1.mem_ready = s_rdy[1]; bus1.op = cur_op[1];
            #1;
            for (int i = 0; i < 2; i++) begin
                got     = (i == 0) ? obs_out0 : obs_out1;
                got_imm = (i == 0) ? bus0.ImmSrc : bus1.ImmSrc;
                got_ill = (i == 0) ? bus0.illegal_instr : bus1.illegal_instr;
                got_bus = (i == 0) ? bus0.bus_error : bus1.bus_error;
                if (c != 0) begin
                    check_val($sformatf("d%0d outputs ph%0d", i, m_ph[i]),
                              32'(got), 32'(exp_out(m_ph[i], s_rdy[i])));
                    check_val($sformatf("d%0d ImmSrc", i), 32'(got_imm), 32'(exp_imm(cur_op[i])));
                    check_val($sformatf("d%0d illegal_instr", i), 32'(got_ill), 32'(m_ill[i]));
                    check_val($sformatf("d%0d bus_error", i), 32'(got_bus), 32'(m_bus[i]));
                end

                if (s_rst[i]) begin
                    cc_valid[i] = 0;
                end else if (got[12]) begin
                    if (cc_valid[i])
                        check_val($sformatf("d%0d cycles op %b", i, cc_op[i]),
                                  32'(cc_cnt[i]), 32'(base_cycles(cc_op[i]) + cc_waits[i]));
                    cc_cnt[i] = 1; cc_waits[i] = 0; cc_valid[i] = 1;
                end else begin
                    cc_cnt[i]++;
                    if (is_mem(m_ph[i]) && !s_rdy[i]) cc_waits[i]++;
                end

                fetch_done = !s_rst[i] && m_ph[i] == P_F && s_rdy[i];
                model_step(i, s_rst[i], s_rdy[i], cur_op[i]);
                if (fetch_done) begin
                    if (i == 0 && q_op0.size() != 0)      cur_op[i] = q_op0.pop_front();
                    else if (i == 1 && q_op1.size() != 0) cur_op[i] = q_op1.pop_front();
                    else                                  cur_op[i] = rand_op();
                    cc_op[i] = cur_op[i];
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control unit for the RISC-V core. It replaces the single-cycle main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a memory ready/request handshake, an optional memory-timeout watchdog, and a selectable illegal-opcode policy. It drives the shared-datapath muxes and enables; ALU function decode stays in the existing ALU decoder.

## Interface
- `TRAP_ILLEGAL`, default 1: 1 sends unknown opcodes to ERROR; 0 retires them as NOPs.
- `MEM_TIMEOUT`, default 0: number of cycles a memory state may wait for `mem_ready`; 0 disables the watchdog.
- `CNT_W`, default `$clog2(MEM_TIMEOUT+1)`, minimum 1: width of the wait counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: a memory access is in progress.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `IRWrite` out 1: instruction register and OldPC load enable.
- `PCUpdate` out 1: unconditional PC write enable.
- `Branch` out 1: conditional PC write; datapath ANDs it with Zero.
- `RegWrite` out 1: register file write enable.
- `MemWrite` out 1: store enable.
- `ALUSrcA` out 2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2: ALU operand B select. 00 = rs2, 01 = ImmExt, 10 = 4.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = use funct fields.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc` out 3: combinational from `op`.
  - 000: lw, I-ALU, jalr.
  - 001: sw.
  - 010: B-type.
  - 011: jal.
  - 100: auipc, lui.
  - 000: all other opcodes.
- `illegal_instr` out 1: sticky illegal-opcode flag.
- `bus_error` out 1: sticky memory-timeout flag.

## Operation
Any output not listed for a state is 0. `mem_req` is 1 in FETCH, MEMREAD and MEMWRITE only.

State outputs:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate = `mem_ready`.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Computes the branch/jal/auipc target into ALUOut.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held until `mem_ready`.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00.
- ERROR: all enables 0, `mem_req`=0.

Transitions:
- FETCH: to DECODE when `mem_ready`, else stay.
- DECODE, by `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0010111 → ALUWB (auipc).
  - 0110111 → LUI.
  - 0000000 → FETCH (NOP).
  - Any other opcode → ERROR with `illegal_instr`=1 if `TRAP_ILLEGAL`, else FETCH.
- MEMADR: lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: to MEMWB on `mem_ready`, else stay.
- MEMWRITE: to FETCH on `mem_ready`, else stay.
- JALR → JAL → ALUWB.
- MEMWB, ALUWB, BEQ → FETCH.
- EXECUTER, EXECUTEI, LUI → ALUWB.
- ERROR: stays until `reset`.

Watchdog (only when `MEM_TIMEOUT` > 0):
- The wait counter clears on every state change and on `mem_ready`.
- It increments each cycle spent in FETCH, MEMREAD or MEMWRITE with `mem_ready`=0.
- When it reaches `MEM_TIMEOUT` and `mem_ready` is still 0, the next state is ERROR and `bus_error` is set.
- The counter saturates and never wraps.

## Timing
- Reset: state=FETCH, counter=0, flags=0. Outputs take FETCH values the cycle after `reset`, with `mem_req`=1.
- `reset` overrides everything, including mid-MEMWRITE and ERROR.
- Moore outputs are a function of registered state only. Exceptions:
  - IRWrite/PCUpdate in FETCH are combinational from `mem_ready`.
  - `ImmSrc` is combinational from `op`.
- Zero-wait cycle counts:
  - lw: 5.
  - sw: 4.
  - R/I-ALU: 4.
  - beq: 3.
  - jal: 4.
  - jalr: 5.
  - auipc: 3.
  - lui: 4.
- Each wait cycle adds exactly one cycle.
- `mem_ready` in non-memory states is ignored.
- A `mem_ready` arriving in the same cycle the counter hits `MEM_TIMEOUT` wins: the access completes and no error is raised.

## Structure
- `riscv_ctrl_pkg` holds:
  - the `state_t` enum;
  - opcode localparams;
  - ALUSrcA/B, ResultSrc, ALUOp and ImmSrc encodings, shared with the datapath and ALU decoder.
- One sub-module, `immsrc_dec`: combinational `op` → `ImmSrc`, reused by the pipelined core.

## Test plan
- lw, `mem_ready` tied 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 in cycle 5 only.
- sw, `mem_ready` low for 2 cycles in MEMWRITE: MemWrite=1 for exactly 3 cycles, then FETCH. No RegWrite.
- jalr (op 1100111):
  - JALR shows ALUSrcA=10, ALUSrcB=01.
  - JAL shows PCUpdate=1.
  - ALUWB shows RegWrite=1.
  - Total of 5 cycles.
- op 1111111 with `TRAP_ILLEGAL`=1: ERROR reached, `illegal_instr`=1, all enables 0 until `reset`. With `TRAP_ILLEGAL`=0: back to FETCH after DECODE, flag stays 0.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH: ERROR entered after 4 wait cycles, `bus_error`=1. A repeat run with `mem_ready`=1 on the 4th wait cycle completes normally.
- `reset` asserted mid-MEMWRITE: next cycle state is FETCH, MemWrite=0, `mem_req`=1, flags 0.
